eight_pt_ifft: RTL and testbench
================================

# eight_pt_ifft

Serial-in, serial-out 8-point inverse FFT with 1/8 scaling. It turns frequency-domain bins back into time-domain samples for the synthesis side of the datapath, and is the counterpart of the 8-point forward FFT. A single time-multiplexed radix-2 DIT butterfly is driven by an FSM, with valid/ready handshakes on both sides. Complex, signed, two's-complement fixed point throughout.

## Interface
- N, 4, width exponent; sample width W = 2**N (16 by default)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input bin present
- in_ready  out  1  block accepts a bin this cycle
- in_re, in_im  in  W each  input bin X[k], signed; k implied by accept order 0..7
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts the sample
- out_re, out_im  out  W each  output sample x[n], signed; n = 0..7 in order
- out_last  out  1  high with sample n = 7
- busy  out  1  high in COMPUTE and UNLOAD

## Operation
- Storage: 8 complex registers, mem[0..7], each holding re and im of W bits.
- FSM states: LOAD, COMPUTE, UNLOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, store bin k at mem[bitrev3(k)], then increment k.
  - After k = 7 is accepted, go to COMPUTE.
- COMPUTE: 12 cycles, one butterfly per cycle.
  - Counter sequence is stage s = 0..2 (outer loop), butterfly b = 0..3 (inner loop).
  - span = 1<<s.
  - top = ((b>>s)<<(s+1)) | (b & (span-1)); bot = top + span.
  - Twiddle index tk = (b & (span-1)) << (2-s).
  - Twiddle is the conjugate (inverse) twiddle e^{+j2π·tk/8}.
  - The butterfly reads mem[top] and mem[bot] and writes both back in the same cycle.
  - After s = 2, b = 3, go to UNLOAD.
- Butterfly arithmetic:
  - P = W·mem[bot].
  - mem[top] ← (mem[top] + P) >>> 1.
  - mem[bot] ← (mem[top] − P) >>> 1.
  - Sums are formed in W+1 bits, then arithmetic-shifted right by 1. The result is truncated toward −∞ and always fits in W bits.
- Twiddle products, with C = round(0.70710678·2^(W−1)) = 23170 for W = 16:
  - tk0: P = (br, bi), exact.
  - tk1: P = ((br−bi)·C, (br+bi)·C) >>> (W−1).
  - tk2: P = (−bi, br), exact.
  - tk3: P = ((−br−bi)·C, (br−bi)·C) >>> (W−1).
  - Intermediates use W+1-bit operands and 2W+1-bit products.
- UNLOAD:
  - out_valid = 1; out_re/out_im = mem[n]; out_last = (n == 7).
  - On out_valid & out_ready, increment n.
  - After n = 7 is accepted, go to LOAD and clear k and n.
- Result: x[n] = (1/8)·Σ X[k]·e^{+j2πkn/8}, within ±2 LSB.

## Timing
- Reset values (rst high at a clock edge):
  - state = LOAD, k = n = 0, s = b = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0.
  - out_re = out_im = 0.
  - mem contents are don't-care.
- Reset mid-frame, in any state: abandons the frame. No partial output is ever emitted.
- Load: 8 accepts. in_valid gaps are allowed; k holds during gaps.
- Latency: the last accept happens at edge t. COMPUTE occupies cycles t+1 … t+12. out_valid first goes high in cycle t+13.
- Backpressure: while out_valid & !out_ready, out_re, out_im and out_last hold stable.
- in_ready = 0 in COMPUTE and UNLOAD; in_valid is ignored there.
- Input and output never overlap; there is no ping-pong buffering.
- Throughput: 8 + 12 + 8 = 28 cycles per frame at full handshake rate.
- Back-to-back frames: in_ready rises in the cycle after the out_last accept.

## Structure
- Shared constants go in the shared package/header alongside the forward-FFT constants:
  - W derived from N.
  - Twiddle constant C.
  - FSM state encodings.
  - bitrev3 function.
- One sub-module, ifft_butterfly (combinational):
  - Inputs: top and bottom complex operands plus tk.
  - Outputs: the two scaled results.
  - The top level contains the FSM, counters, address generation and the mem register file.

## Test plan
- Impulse X[0] = (8000,0), all others 0, out_ready = 1 → all 8 outputs (1000,0). out_valid first rises 13 cycles after the last accept. out_last is high only on n = 7.
- Impulse X[1] = (8000,0) → outputs ≈ (1000,0), (707,707), (0,1000), (−707,707), (−1000,0), (−707,−707), (0,−1000), (707,−707), each within ±2.
- Constant X[k] = (800,−400) for all k → x[0] = (800,−400), x[1..7] = (0,0) within ±1.
- Output backpressure: out_ready pattern 1,0,0,1,… with X[0] = (8000,0) → outputs hold stable while out_ready = 0. Exactly 8 transfers, in order. in_ready = 0 until the final transfer.
- Input gaps, then back-to-back frames: in_valid toggling during load, frame 1 = the X[0] impulse, frame 2 = the X[1] impulse → correct results for both frames. in_ready rises in the cycle after frame 1's out_last accept.
- Reset mid-COMPUTE, asserted at butterfly 5:
  - The next cycle shows in_ready = 1, out_valid = 0, busy = 0, outputs 0.
  - A fresh X[0] = (8000,0) frame then yields all outputs (1000,0).

Source files
------------

// File: rtl/eight_pt_ifft_pkg.sv
// Constants shared by the 8-point FFT/IFFT pair: sample width, twiddle, FSM states, bit reversal.
package eight_pt_ifft_pkg;

   localparam int unsigned N = 4;
   localparam int unsigned W = 1 << N;

   // round(cos(pi/4) * 2^(W-1)); 23170 for W = 16
   localparam logic [W:0] C = (W + 1)'($rtoi(0.70710678 * (2.0 ** (W - 1)) + 0.5));

   typedef enum logic [1:0] {
      StLoad,
      StCompute,
      StUnload
   } state_e;

   typedef struct packed {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
   } cplx_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

endpackage

// File: rtl/eight_pt_ifft_if.sv
// Streaming bin-in / sample-out handshake bundle of the 8-point IFFT.
interface eight_pt_ifft_if;

   logic                                     in_valid;
   logic                                     in_ready;
   logic signed [eight_pt_ifft_pkg::W-1:0]   in_re;
   logic signed [eight_pt_ifft_pkg::W-1:0]   in_im;
   logic                                     out_valid;
   logic                                     out_ready;
   logic signed [eight_pt_ifft_pkg::W-1:0]   out_re;
   logic signed [eight_pt_ifft_pkg::W-1:0]   out_im;
   logic                                     out_last;
   logic                                     busy;

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_last, busy
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_last, busy
   );

endinterface

// File: rtl/eight_pt_ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with conjugate twiddle and a 1/2 scale on each output.
module eight_pt_ifft_butterfly
   import eight_pt_ifft_pkg::*;
(
   input  cplx_t      a,
   input  cplx_t      b,
   input  logic [1:0] tk,
   output cplx_t      y_top,
   output cplx_t      y_bot
);

   localparam logic signed [2*W:0] Cw = (2 * W + 1)'(C);

   logic signed [W:0]   ar, ai, br, bi, pr, pi;
   logic signed [2*W:0] k0, k1, m0, m1;
   logic signed [W:0]   st_re, st_im, sb_re, sb_im;

   always_comb begin
      ar = {a.re[W-1], a.re};
      ai = {a.im[W-1], a.im};
      br = {b.re[W-1], b.re};
      bi = {b.im[W-1], b.im};
      k0 = '0;
      k1 = '0;
      unique case (tk)
         2'd1: begin
            k0 = (2 * W + 1)'(br - bi);
            k1 = (2 * W + 1)'(br + bi);
         end
         2'd3: begin
            k0 = (2 * W + 1)'(-br - bi);
            k1 = (2 * W + 1)'(br - bi);
         end
         default: ;
      endcase
      m0 = k0 * Cw;
      m1 = k1 * Cw;
      pr = '0;
      pi = '0;
      unique case (tk)
         2'd0: begin
            pr = br;
            pi = bi;
         end
         2'd2: begin
            pr = -bi;
            pi = br;
         end
         default: begin
            // bits [2W-1:W-1] are the product arithmetic-shifted right by W-1
            pr = m0[2*W-1:W-1];
            pi = m1[2*W-1:W-1];
         end
      endcase
      st_re = ar + pr;
      st_im = ai + pi;
      sb_re = ar - pr;
      sb_im = ai - pi;
   end

   assign y_top = '{re: st_re[W:1], im: st_im[W:1]};
   assign y_bot = '{re: sb_re[W:1], im: sb_im[W:1]};

   logic unused_bits;
   assign unused_bits = ^{m0[2*W], m0[W-2:0], m1[2*W], m1[W-2:0],
                          st_re[0], st_im[0], sb_re[0], sb_im[0]};

endmodule

// File: rtl/eight_pt_ifft.sv
// Serial-in/serial-out 8-point inverse FFT: load 8 bins, 12 in-place butterflies, unload 8 samples.
module eight_pt_ifft
   import eight_pt_ifft_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   eight_pt_ifft_if.slave  bus
);

   cplx_t      mem_q [8];
   state_e     state_q;
   logic [2:0] k_q, n_q;
   logic [1:0] s_q, b_q;
   logic       in_ready_q, out_valid_q, out_last_q, busy_q;
   cplx_t      out_q;

   logic [2:0] span, low, top, bot;
   logic [1:0] tk;
   cplx_t      bf_top, bf_bot;

   // In-place DIT addressing: stage s pairs elements span apart within blocks of 2*span.
   always_comb begin
      span = 3'd1 << s_q;
      low  = {1'b0, b_q} & (span - 3'd1);
      top  = ((({1'b0, b_q}) >> s_q) << (s_q + 2'd1)) | low;
      bot  = top + span;
      tk   = 2'(low << (2'd2 - s_q));
   end

   eight_pt_ifft_butterfly u_bfly (
      .a     (mem_q[top]),
      .b     (mem_q[bot]),
      .tk    (tk),
      .y_top (bf_top),
      .y_bot (bf_bot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StLoad;
         k_q         <= '0;
         n_q         <= '0;
         s_q         <= '0;
         b_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_q       <= '0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (bus.in_valid && in_ready_q) begin
                  mem_q[bitrev3(k_q)] <= '{re: bus.in_re, im: bus.in_im};
                  k_q <= k_q + 3'd1;
                  if (k_q == 3'd7) begin
                     state_q    <= StCompute;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end
               end
            end
            StCompute: begin
               mem_q[top] <= bf_top;
               mem_q[bot] <= bf_bot;
               b_q <= b_q + 2'd1;
               if (b_q == 2'd3) begin
                  s_q <= s_q + 2'd1;
                  if (s_q == 2'd2) begin
                     // mem[0] was finalised by butterfly (2,0), so it can be presented now
                     state_q     <= StUnload;
                     s_q         <= '0;
                     out_valid_q <= 1'b1;
                     out_q       <= mem_q[0];
                  end
               end
            end
            StUnload: begin
               if (out_valid_q && bus.out_ready) begin
                  if (n_q == 3'd7) begin
                     state_q     <= StLoad;
                     n_q         <= '0;
                     k_q         <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     out_q       <= '0;
                  end else begin
                     n_q        <= n_q + 3'd1;
                     out_q      <= mem_q[n_q + 3'd1];
                     out_last_q <= (n_q == 3'd6);
                  end
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_q.re;
   assign bus.out_im    = out_q.im;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_eight_pt_ifft.sv
// Self-checking bench: DFT reference model in real arithmetic plus directed frames.
module tb_eight_pt_ifft;
   import eight_pt_ifft_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eight_pt_ifft_if ifc ();

   eight_pt_ifft dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int checks = 0;
   int passed = 0;

   real exp_re_q[$], exp_im_q[$], tol_q[$];
   real m_re[8], m_im[8];
   int  got_re[8], got_im[8];
   int  out_n = 0;
   int  xfers = 0;
   bit  after_last = 0;
   bit  stall_prev = 0;
   int  hold_re, hold_im;
   bit  hold_last;
   real er, ei, tl, d_re, d_im;

   int imp0_re[8]  = '{8000, 0, 0, 0, 0, 0, 0, 0};
   int imp1_re[8]  = '{0, 8000, 0, 0, 0, 0, 0, 0};
   int zero8[8]    = '{0, 0, 0, 0, 0, 0, 0, 0};
   int cst_re[8]   = '{800, 800, 800, 800, 800, 800, 800, 800};
   int cst_im[8]   = '{-400, -400, -400, -400, -400, -400, -400, -400};
   bit pat[4]      = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   // x[n] = (1/8) * sum_k X[k] * e^{+j*2*pi*k*n/8}
   task automatic model_calc(input int xr[8], input int xi[8]);
      real ang, sr, si;
      for (int n = 0; n < 8; n++) begin
         sr = 0.0;
         si = 0.0;
         for (int k = 0; k < 8; k++) begin
            ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
            sr += real'(xr[k]) * $cos(ang) - real'(xi[k]) * $sin(ang);
            si += real'(xr[k]) * $sin(ang) + real'(xi[k]) * $cos(ang);
         end
         m_re[n] = sr / 8.0;
         m_im[n] = si / 8.0;
      end
   endtask

   task automatic push_model(input int xr[8], input int xi[8], input real tol);
      model_calc(xr, xi);
      for (int n = 0; n < 8; n++) begin
         exp_re_q.push_back(m_re[n]);
         exp_im_q.push_back(m_im[n]);
         tol_q.push_back(tol);
      end
   endtask

   // Compare process: every output transfer against the model, plus handshake rules.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         after_last = 1'b0;
      end else begin
         if (after_last) begin
            check(ifc.in_ready && !ifc.out_valid, "in_ready_after_last", int'(ifc.in_ready), 1);
            after_last = 1'b0;
         end
         if (stall_prev) begin
            check(ifc.out_valid && int'(ifc.out_re) == hold_re && int'(ifc.out_im) == hold_im
                  && ifc.out_last == hold_last, "hold_stable", int'(ifc.out_re), hold_re);
         end
         stall_prev = ifc.out_valid && !ifc.out_ready;
         hold_re    = int'(ifc.out_re);
         hold_im    = int'(ifc.out_im);
         hold_last  = ifc.out_last;
         if (ifc.out_valid && ifc.out_ready) begin
            check(exp_re_q.size() != 0, "output_expected", exp_re_q.size(), 1);
            if (exp_re_q.size() != 0) begin
               er   = exp_re_q.pop_front();
               ei   = exp_im_q.pop_front();
               tl   = tol_q.pop_front();
               d_re = real'(int'(ifc.out_re)) - er;
               d_im = real'(int'(ifc.out_im)) - ei;
               check(d_re <= tl && d_re >= -tl, $sformatf("x_re[%0d]", out_n), int'(ifc.out_re),
                     rnd(er));
               check(d_im <= tl && d_im >= -tl, $sformatf("x_im[%0d]", out_n), int'(ifc.out_im),
                     rnd(ei));
               check(ifc.out_last == (out_n == 7), $sformatf("out_last[%0d]", out_n),
                     int'(ifc.out_last), int'(out_n == 7));
               check(!ifc.in_ready, "in_ready_during_unload", int'(ifc.in_ready), 0);
               got_re[out_n] = int'(ifc.out_re);
               got_im[out_n] = int'(ifc.out_im);
               if (out_n == 7) after_last = 1'b1;
               out_n = (out_n + 1) % 8;
               xfers++;
            end
         end
      end
   end

   task automatic send_frame(input int xr[8], input int xi[8], input bit gaps, input bit push,
                             input real tol);
      int w;
      if (push) push_model(xr, xi, tol);
      for (int k = 0; k < 8; k++) begin
         if (gaps && (k % 2 == 1)) begin
            ifc.in_valid = 1'b0;
            ifc.in_re    = 16'sh7fff;
            ifc.in_im    = -16'sd1;
            @(posedge clk);
            #1;
         end
         ifc.in_valid = 1'b1;
         ifc.in_re    = W'(xr[k]);
         ifc.in_im    = W'(xi[k]);
         w = 0;
         while (w < 100) begin
            @(negedge clk);
            if (ifc.in_ready) break;
            w++;
         end
         if (w == 100) begin
            $display("FAIL in_accept_timeout: got %0d, expected 1", int'(ifc.in_ready));
            $fatal(1, "input handshake stalled");
         end
         @(posedge clk);
         #1;
         ifc.in_valid = 1'b0;
      end
   endtask

   task automatic drain(input bit bp);
      int w = 0;
      while (exp_re_q.size() != 0 && w < 400) begin
         if (bp) ifc.out_ready = pat[w % 4];
         @(posedge clk);
         #1;
         w++;
      end
      ifc.out_ready = 1'b1;
      check(exp_re_q.size() == 0, "drain_timeout", exp_re_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, x0, bad;
      ifc.in_valid  = 1'b0;
      ifc.in_re     = '0;
      ifc.in_im     = '0;
      ifc.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check(ifc.in_ready == 1'b1, "rst_in_ready", int'(ifc.in_ready), 1);
      check(ifc.out_valid == 1'b0, "rst_out_valid", int'(ifc.out_valid), 0);
      check(ifc.out_last == 1'b0, "rst_out_last", int'(ifc.out_last), 0);
      check(ifc.busy == 1'b0, "rst_busy", int'(ifc.busy), 0);
      check(ifc.out_re == '0, "rst_out_re", int'(ifc.out_re), 0);
      check(ifc.out_im == '0, "rst_out_im", int'(ifc.out_im), 0);
      rst = 1'b0;

      // Hand-computed values that pin the model itself
      model_calc(imp1_re, zero8);
      check(rnd(m_re[1]) == 707, "model_x1_re1", rnd(m_re[1]), 707);
      check(rnd(m_im[1]) == 707, "model_x1_im1", rnd(m_im[1]), 707);
      check(rnd(m_re[4]) == -1000, "model_x1_re4", rnd(m_re[4]), -1000);
      check(rnd(m_im[6]) == -1000, "model_x1_im6", rnd(m_im[6]), -1000);
      model_calc(cst_re, cst_im);
      check(rnd(m_re[0]) == 800 && rnd(m_im[0]) == -400, "model_cst_0", rnd(m_re[0]), 800);
      check(rnd(m_re[3]) == 0 && rnd(m_im[3]) == 0, "model_cst_3", rnd(m_re[3]), 0);

      // Impulse at X[0]; junk on in_valid during COMPUTE must be ignored
      send_frame(imp0_re, zero8, 1'b0, 1'b1, 0.0);
      ifc.in_valid = 1'b1;
      ifc.in_re    = 16'sd1234;
      ifc.in_im    = -16'sd77;
      lat = 0;
      while (!ifc.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) check(ifc.busy && !ifc.in_ready, "busy_in_compute", int'(ifc.busy), 1);
      end
      ifc.in_valid = 1'b0;
      // accept cycle t, COMPUTE t+1..t+12, out_valid in t+13: 12 edges after the accept edge
      check(lat == 12, "latency_edges", lat, 12);
      drain(1'b0);
      check(got_re[0] == 1000 && got_im[0] == 0, "imp0_x0", got_re[0], 1000);
      check(got_re[7] == 1000 && got_im[7] == 0, "imp0_x7", got_re[7], 1000);

      // Impulse at X[1]: all four twiddles
      send_frame(imp1_re, zero8, 1'b0, 1'b1, 2.0);
      drain(1'b0);
      check(got_re[1] >= 705 && got_re[1] <= 709, "imp1_x1_re", got_re[1], 707);
      check(got_im[6] >= -1002 && got_im[6] <= -998, "imp1_x6_im", got_im[6], -1000);

      // Constant spectrum
      send_frame(cst_re, cst_im, 1'b0, 1'b1, 1.0);
      drain(1'b0);
      check(got_re[0] == 800 && got_im[0] == -400, "cst_x0", got_re[0], 800);

      // Output backpressure 1,0,0,1,...
      x0 = xfers;
      send_frame(imp0_re, zero8, 1'b0, 1'b1, 0.0);
      drain(1'b1);
      check(xfers - x0 == 8, "bp_transfer_count", xfers - x0, 8);

      // Input gaps, then back-to-back frames
      x0 = xfers;
      send_frame(imp0_re, zero8, 1'b1, 1'b1, 0.0);
      send_frame(imp1_re, zero8, 1'b1, 1'b1, 2.0);
      drain(1'b0);
      check(xfers - x0 == 16, "b2b_transfer_count", xfers - x0, 16);

      // Reset while COMPUTE is mid-frame (butterfly 5 on the clock edge that samples rst)
      send_frame(cst_re, cst_im, 1'b0, 1'b0, 0.0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check(ifc.in_ready == 1'b1, "midrst_in_ready", int'(ifc.in_ready), 1);
      check(ifc.out_valid == 1'b0, "midrst_out_valid", int'(ifc.out_valid), 0);
      check(ifc.busy == 1'b0, "midrst_busy", int'(ifc.busy), 0);
      check(ifc.out_re == '0 && ifc.out_im == '0, "midrst_out", int'(ifc.out_re), 0);
      rst = 1'b0;
      out_n = 0;
      x0 = xfers;
      send_frame(imp0_re, zero8, 1'b0, 1'b1, 0.0);
      drain(1'b0);
      check(xfers - x0 == 8, "post_rst_transfer_count", xfers - x0, 8);
      bad = 0;
      for (int n = 0; n < 8; n++) if (got_re[n] != 1000 || got_im[n] != 0) bad++;
      check(bad == 0, "post_rst_all_1000", bad, 0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
